// File: rtl/daq_mem_pkg.sv
// -----------------------------------------------------------------------------
// daq_mem_pkg
// Types and constants shared by the DDR sample path (sample_mem_writer, hal and
// control_unit): memory word/address widths, the writer FSM state encoding and
// small arithmetic helpers for the ring-buffer bookkeeping.
// -----------------------------------------------------------------------------
package daq_mem_pkg;

    localparam int MEM_ADDR_W = 26;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } writer_state_t;

    // Next ring offset: the last slot folds back to slot 0.
    function automatic logic [MEM_ADDR_W-1:0] ring_next(
        input logic [MEM_ADDR_W-1:0] off,
        input logic [MEM_ADDR_W-1:0] last
    );
        logic [MEM_ADDR_W-1:0] nxt;
        if (off == last) begin
            nxt = {MEM_ADDR_W{1'b0}};
        end else begin
            nxt = off + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] nxt;
        if (v == 16'hFFFF) begin
            nxt = v;
        end else begin
            nxt = v + 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO: register array with binary read/write pointers carrying an
// extra wrap bit, so full and empty are told apart by the pointer difference.
// The caller must not push when full nor pop when empty. Read data is the
// current head (first-word-fall-through); a word written at an edge is visible
// at the head only after that edge, so there is no same-cycle bypass.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (pointers only)
//   i_push, i_data   write strobe and data
//   i_pop            advance the head
//   o_data           current head word
//   o_full, o_empty  occupancy flags
//   o_level          occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_level;

    // Storage array: written on push, never reset (contents are don't-care when empty).
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers with wrap bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= {(AW+1){1'b0}};
            r_rptr <= {(AW+1){1'b0}};
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (i_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign w_level = r_wptr - r_rptr;
    assign o_level = w_level;
    assign o_full  = (w_level == (AW+1)'(DEPTH));
    assign o_empty = (w_level == {(AW+1){1'b0}});
    assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/sample_mem_writer.sv
// -----------------------------------------------------------------------------
// sample_mem_writer
// Buffers 32-bit ADC sample words in a FIFO and drains them, one single-word
// write at a time, into a DDR ring buffer starting at BASE_ADDR via the hal
// write interface (memory_write_req / memory_addr / memory_data_write /
// memory_busy). A write that never sees memory_busy within ACK_TIMEOUT cycles
// is abandoned (not retried) and flagged.
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   enable             1 = drain FIFO to memory (never aborts an in-flight write)
//   s_valid/s_data     incoming sample word
//   s_ready            FIFO can accept this cycle (!full)
//   memory_write_req   one-cycle write strobe
//   memory_addr        word address, held until the next write
//   memory_data_write  write data, held with memory_addr
//   memory_busy        hal busy
//   wr_offset          next ring offset to be written
//   wrap_count         ring wraps, saturating
//   fill_level         FIFO occupancy
//   overflow           sticky: a sample was dropped
//   ack_timeout        sticky: a write was abandoned
//   clear_flags        clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module sample_mem_writer
    import daq_mem_pkg::*;
#(
    parameter int                    FIFO_DEPTH  = 16,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = 26'h0,
    parameter int                    RING_WORDS  = 2**20,
    parameter int                    ACK_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    input  logic [MEM_DATA_W-1:0]         s_data,
    output logic                          s_ready,
    output logic                          memory_write_req,
    output logic [MEM_ADDR_W-1:0]         memory_addr,
    output logic [MEM_DATA_W-1:0]         memory_data_write,
    input  logic                          memory_busy,
    output logic [MEM_ADDR_W-1:0]         wr_offset,
    output logic [15:0]                   wrap_count,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          ack_timeout,
    input  logic                          clear_flags
);

    localparam int                    TMR_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [MEM_ADDR_W-1:0] RING_LAST = MEM_ADDR_W'(RING_WORDS - 1);

    writer_state_t               r_state;
    writer_state_t               w_next_state;
    logic                        r_alive;
    logic                        r_req;
    logic [MEM_ADDR_W-1:0]       r_addr;
    logic [MEM_DATA_W-1:0]       r_data;
    logic [MEM_ADDR_W-1:0]       r_offset;
    logic [15:0]                 r_wrap;
    logic [TMR_W-1:0]            r_timer;
    logic                        r_overflow;
    logic                        r_ack_timeout;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_drop;
    logic                        w_timeout_evt;
    logic                        w_full;
    logic                        w_empty;
    logic [MEM_DATA_W-1:0]       w_head;
    logic [$clog2(FIFO_DEPTH):0] w_level;

    sync_fifo #(
        .WIDTH (MEM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // s_ready is held low while reset is asserted and rises on the first clock after release.
    assign s_ready = r_alive & ~w_full;
    assign w_push  = s_valid & s_ready;
    assign w_drop  = s_valid & ~s_ready;

    // Marks the first clock edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !w_empty && !memory_busy) begin
                    w_pop        = 1'b1;
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (memory_busy) begin
                    w_next_state = WAIT_DONE;
                end else if (r_timer == TMR_LAST) begin
                    w_timeout_evt = 1'b1;
                    w_next_state  = IDLE;
                end else begin
                    w_next_state = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!memory_busy) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, write strobe, address/data latch, ring pointer and ack timer.
    // The strobe is registered from the next state so it is high exactly in ISSUE
    // and still drops immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_addr   <= {MEM_ADDR_W{1'b0}};
            r_data   <= {MEM_DATA_W{1'b0}};
            r_offset <= {MEM_ADDR_W{1'b0}};
            r_wrap   <= 16'd0;
            r_timer  <= {TMR_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_req   <= (w_next_state == ISSUE);
            if (w_pop) begin
                r_addr <= BASE_ADDR + r_offset;
                r_data <= w_head;
            end
            if (r_state == ISSUE) begin
                r_offset <= ring_next(r_offset, RING_LAST);
                if (r_offset == RING_LAST) begin
                    r_wrap <= sat_inc16(r_wrap);
                end
                r_timer <= {TMR_W{1'b0}};
            end else if ((r_state == WAIT_ACK) && !memory_busy) begin
                r_timer <= r_timer + {{(TMR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as clear_flags keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_flags) begin
            r_overflow <= 1'b0;
        end
    end

    // Sticky ack-timeout flag; a timeout in the same cycle as clear_flags keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_timeout <= 1'b0;
        end else if (w_timeout_evt) begin
            r_ack_timeout <= 1'b1;
        end else if (clear_flags) begin
            r_ack_timeout <= 1'b0;
        end
    end

    assign memory_write_req  = r_req;
    assign memory_addr       = r_addr;
    assign memory_data_write = r_data;
    assign wr_offset         = r_offset;
    assign wrap_count        = r_wrap;
    assign fill_level        = w_level;
    assign overflow          = r_overflow;
    assign ack_timeout       = r_ack_timeout;

endmodule

// File: tb/tb_sample_mem_writer.sv
`timescale 1ns/1ps
module tb_sample_mem_writer;

    localparam int          FIFO_DEPTH = 16;
    localparam logic [25:0] BASE       = 26'h100;
    localparam int          RING       = 4;
    localparam int          ACK_TO     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_ready;
    logic        memory_write_req;
    logic [25:0] memory_addr;
    logic [31:0] memory_data_write;
    logic        memory_busy;
    logic [25:0] wr_offset;
    logic [15:0] wrap_count;
    logic [4:0]  fill_level;
    logic        overflow;
    logic        ack_timeout;
    logic        clear_flags = 1'b0;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [31:0] data;
        logic [25:0] exp_addr;
        logic [25:0] exp_off;
        logic [15:0] exp_wrap;
    } vec_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          busy_len = 2;
    bit          hang = 1'b0;
    int          req_count = 0;
    int          rc;
    logic [25:0] exp_off = 26'd0;
    bit          acc;
    bit          found;
    vec_t        vecs[9];

    sample_mem_writer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BASE_ADDR   (BASE),
        .RING_WORDS  (RING),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .memory_write_req  (memory_write_req),
        .memory_addr       (memory_addr),
        .memory_data_write (memory_data_write),
        .memory_busy       (memory_busy),
        .wr_offset         (wr_offset),
        .wrap_count        (wrap_count),
        .fill_level        (fill_level),
        .overflow          (overflow),
        .ack_timeout       (ack_timeout),
        .clear_flags       (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write for each accepted word: address follows the bench's own ring model.
    task automatic sb_add(input logic [31:0] d);
        sb_q.push_back('{BASE + exp_off, d});
        exp_off = (exp_off == 26'(RING - 1)) ? 26'd0 : exp_off + 26'd1;
    endtask

    task automatic push(input logic [31:0] d, output bit accepted);
        s_valid  = 1'b1;
        s_data   = d;
        accepted = s_ready;
        if (accepted) sb_add(d);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_req(input string name, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (memory_write_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_drain(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (sb_q.size() == 0 && fill_level == 5'd0 && memory_busy == 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, done, 1);
    endtask

    task automatic do_reset(input bit check);
        reset       = 1'b1;
        s_valid     = 1'b0;
        clear_flags = 1'b0;
        #1;
        if (check) begin
            chk("rst_req", memory_write_req, 0);
            chk("rst_addr", memory_addr, 0);
            chk("rst_data", memory_data_write, 0);
            chk("rst_wr_offset", wr_offset, 0);
            chk("rst_wrap", wrap_count, 0);
            chk("rst_fill", fill_level, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_ack_timeout", ack_timeout, 0);
            chk("rst_s_ready", s_ready, 0);
        end
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
        exp_off = 26'd0;
        if (check) chk("rst_ready_held", s_ready, 0);
        tick();
        if (check) chk("rst_ready_up", s_ready, 1);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && memory_write_req === 1'b1) begin
            req_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_req actual_addr=%0h required=no_write", memory_addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_addr", memory_addr, mon_e.addr);
                chk("sb_data", memory_data_write, mon_e.data);
            end
        end
    end

    // hal model: raises busy for busy_len cycles starting the cycle after each strobe.
    initial begin
        memory_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (memory_write_req === 1'b1 && !hang && busy_len > 0) begin
                @(posedge clk);
                #1 memory_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 memory_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'hC000_0000, 26'h100, 26'd1, 16'd0};
        vecs[1] = '{32'hC000_0001, 26'h101, 26'd2, 16'd0};
        vecs[2] = '{32'hC000_0002, 26'h102, 26'd3, 16'd0};
        vecs[3] = '{32'hC000_0003, 26'h103, 26'd0, 16'd1};
        vecs[4] = '{32'hC000_0004, 26'h100, 26'd1, 16'd1};
        vecs[5] = '{32'hC000_0005, 26'h101, 26'd2, 16'd1};
        vecs[6] = '{32'hC000_0006, 26'h102, 26'd3, 16'd1};
        vecs[7] = '{32'hC000_0007, 26'h103, 26'd0, 16'd2};
        vecs[8] = '{32'hC000_0008, 26'h100, 26'd1, 16'd2};

        #2;
        // Single word, busy for 2 cycles: strobe exactly two cycles after the push.
        do_reset(1'b1);
        enable   = 1'b1;
        busy_len = 2;
        push(32'hA5A5_0001, acc);
        chk("t1_accept", acc, 1);
        chk("t1_req_n1", memory_write_req, 0);
        tick();
        chk("t1_req_n2", memory_write_req, 1);
        chk("t1_addr", memory_addr, BASE);
        chk("t1_data", memory_data_write, 32'hA5A5_0001);
        tick();
        chk("t1_req_pulse", memory_write_req, 0);
        chk("t1_wr_offset", wr_offset, 1);
        rc = req_count;
        repeat (6) tick();
        chk("t1_no_extra_req", req_count, rc);
        chk("t1_fill", fill_level, 0);

        // Ring of 4 words, 9 writes: addresses wrap and wrap_count reaches 2.
        do_reset(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].data, acc);
            wait_req("t2_req", 12, found);
            chk("t2_addr", memory_addr, vecs[i].exp_addr);
            chk("t2_data", memory_data_write, vecs[i].data);
            tick();
            chk("t2_wr_offset", wr_offset, vecs[i].exp_off);
            chk("t2_wrap", wrap_count, vecs[i].exp_wrap);
        end
        wait_drain("t2_drain", 40);

        // enable=0: fill the FIFO, 17th word overflows, nothing written; then drain in order.
        do_reset(1'b0);
        enable = 1'b0;
        rc = req_count;
        for (int i = 0; i < 16; i++) begin
            push(32'h3000_0000 + 32'(i), acc);
            chk("t3_accept", acc, 1);
        end
        chk("t3_ready_full", s_ready, 0);
        chk("t3_fill_full", fill_level, 16);
        chk("t3_no_overflow_yet", overflow, 0);
        push(32'h3000_00FF, acc);
        chk("t3_drop_17th", acc, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_fill_after", fill_level, 16);
        chk("t3_no_req", req_count, rc);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t3_clear", overflow, 0);
        busy_len = 1;
        enable   = 1'b1;
        wait_drain("t3_drain", 200);
        chk("t3_req_count", req_count - rc, 16);

        // hal never answers: timeout after 8 waiting cycles, next word still issued.
        do_reset(1'b0);
        enable = 1'b1;
        hang   = 1'b1;
        push(32'h4000_0001, acc);
        push(32'h4000_0002, acc);
        wait_req("t4_req1", 5, found);
        repeat (8) tick();
        chk("t4_ack_before", ack_timeout, 0);
        tick();
        chk("t4_ack_set", ack_timeout, 1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t4_ack_cleared", ack_timeout, 0);
        chk("t4_req2", memory_write_req, 1);
        chk("t4_req2_data", memory_data_write, 32'h4000_0002);
        repeat (8) tick();
        chk("t4_ack_before2", ack_timeout, 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t4_set_beats_clear", ack_timeout, 1);
        hang = 1'b0;

        // Reset while in WAIT_DONE with 3 words queued.
        busy_len = 4;
        push(32'h5000_0001, acc);
        push(32'h5000_0002, acc);
        push(32'h5000_0003, acc);
        push(32'h5000_0004, acc);
        chk("t5_fill_pre", fill_level, 3);
        chk("t5_offset_pre", wr_offset, 3);
        reset = 1'b1;
        #1;
        chk("t5_req", memory_write_req, 0);
        chk("t5_fill", fill_level, 0);
        chk("t5_wr_offset", wr_offset, 0);
        chk("t5_ack_timeout", ack_timeout, 0);
        chk("t5_overflow", overflow, 0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        exp_off = 26'd0;
        rc = req_count;
        repeat (12) tick();
        chk("t5_no_req_after", req_count, rc);
        push(32'h5000_00AA, acc);
        wait_req("t5_new_req", 6, found);
        chk("t5_new_addr", memory_addr, BASE);

        // Reset during the strobe cycle drops it at once.
        reset = 1'b1;
        #1;
        chk("t6_req_async", memory_write_req, 0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        exp_off = 26'd0;
        repeat (8) tick();

        // Full FIFO, pop and s_valid together: word dropped, next cycle accepted.
        do_reset(1'b0);
        enable   = 1'b0;
        busy_len = 1;
        for (int i = 0; i < 16; i++) begin
            push(32'h7000_0000 + 32'(i), acc);
        end
        chk("t7_fill_full", fill_level, 16);
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h7000_DEAD;
        chk("t7_ready_full", s_ready, 0);
        tick();
        chk("t7_overflow", overflow, 1);
        chk("t7_ready_next", s_ready, 1);
        chk("t7_fill_pop", fill_level, 15);
        s_data = 32'h7000_BEEF;
        acc    = s_ready;
        if (acc) sb_add(32'h7000_BEEF);
        tick();
        s_valid = 1'b0;
        chk("t7_fill_refill", fill_level, 16);
        wait_drain("t7_drain", 300);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
